// File: rtl/cordic_pkg.sv
// -----------------------------------------------------------------------------
// cordic_pkg
// Shared types and constants for the BF16 hyperbolic CORDIC iteration
// sequencer (Softmax exp path, Vector Engine).
//   state_t      : sequencer states IDLE / NEG / POS / DONE
//   IDX_W        : width of the signed iteration index
//   FIRST_REP    : first hyperbolic repeat index; later ones follow k -> 3k+1
//   total_steps  : number of issued steps for a given (neg, last) pair, used
//                  for step_last generation and for sizing by the datapath
// -----------------------------------------------------------------------------
package cordic_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      NEG  = 2'd1,
      POS  = 2'd2,
      DONE = 2'd3
   } state_t;

   localparam int IDX_W     = 8;
   localparam int FIRST_REP = 4;

   // Steps = expanded-range steps + positive indices + one extra issue for
   // every repeat index (4, 13, 40, ...) that is not beyond the last index.
   // Eight candidates reach far past the largest legal last index.
   function automatic int total_steps(input int neg, input int last);
      int n_rep;
      int k;
      n_rep = 0;
      k     = FIRST_REP;
      for (int i = 0; i < 8; i++) begin
         if (k <= last) begin
            n_rep = n_rep + 1;
            k     = 3 * k + 1;
         end
      end
      return neg + last + n_rep;
   endfunction

endpackage

// File: rtl/cordic_hyp_sequencer.sv
// -----------------------------------------------------------------------------
// cordic_hyp_sequencer
// Emits, per operation, the ordered stream of hyperbolic CORDIC iteration
// indices over a valid/ready handshake so a multi-cycle BF16 add/sub datapath
// can stall it. step_idx feeds the atanh table index and the shift amount.
//
// Optional feature macro: CORDIC_EXT_RANGE_EN
//   defined   : expanded-range indices -(NEG_ITERS-1)..0 are issued first
//   undefined : expanded range compiled out; sequences start at index 1
//
// Ports
//   clk         in   clock
//   rst         in   synchronous active-high reset
//   start       in   begin a sequence (accepted only in IDLE)
//   abort       in   cancel the current sequence (wins over start/handshake)
//   busy        out  high from the cycle after start through the DONE cycle
//   done        out  one-cycle pulse after the last step handshake
//   step_valid  out  step_idx / flags valid
//   step_ready  in   datapath consumed the step
//   step_idx    out  signed iteration index
//   step_rep    out  this issue is the repeat of a repeat index
//   step_first  out  first step of the sequence
//   step_last   out  final step of the sequence
//   step_cnt    out  zero-based ordinal of the current step
// -----------------------------------------------------------------------------
module cordic_hyp_sequencer
   import cordic_pkg::*;
#(
   parameter int NEG_ITERS = 6,
   parameter int LAST_IDX  = 13,
   parameter int CNT_W     = 6
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start,
   input  logic                    abort,
   output logic                    busy,
   output logic                    done,
   output logic                    step_valid,
   input  logic                    step_ready,
   output logic signed [IDX_W-1:0] step_idx,
   output logic                    step_rep,
   output logic                    step_first,
   output logic                    step_last,
   output logic [CNT_W-1:0]        step_cnt
);

`ifdef CORDIC_EXT_RANGE_EN
   localparam int NEG_EFF = NEG_ITERS;
`else
   // Expanded range is compiled out; NEG_ITERS is kept only so the parameter
   // list is identical in both builds.
   localparam int NEG_EFF = NEG_ITERS * 0;
`endif

   localparam int                      TOTAL    = total_steps(NEG_EFF, LAST_IDX);
   localparam logic [CNT_W-1:0]        LAST_CNT = CNT_W'(TOTAL - 1);
   localparam logic [CNT_W-1:0]        CNT_ONE  = CNT_W'(1);
   localparam logic signed [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
   localparam logic signed [IDX_W-1:0] REP_INIT = IDX_W'(FIRST_REP);

   state_t                    r_state,    w_state;
   logic signed [IDX_W-1:0]   r_idx,      w_idx;
   logic signed [IDX_W-1:0]   r_next_rep, w_next_rep;
   logic                      r_rep,      w_rep;
   logic                      r_first,    w_first;
   logic                      r_last,     w_last;
   logic [CNT_W-1:0]          r_cnt,      w_cnt;
   logic                      r_valid,    w_valid;
   logic                      r_busy,     w_busy;
   logic                      r_done,     w_done;
   logic                      w_hs;

   assign w_hs = r_valid & step_ready;

   always_comb begin
      w_state    = r_state;
      w_idx      = r_idx;
      w_next_rep = r_next_rep;
      w_rep      = r_rep;
      w_first    = r_first;
      w_last     = r_last;
      w_cnt      = r_cnt;
      w_valid    = r_valid;
      w_busy     = r_busy;
      w_done     = 1'b0;

      case (r_state)
         IDLE: begin
            if (start && !abort) begin
               w_valid    = 1'b1;
               w_busy     = 1'b1;
               w_first    = 1'b1;
               w_rep      = 1'b0;
               w_cnt      = '0;
               w_next_rep = REP_INIT;
`ifdef CORDIC_EXT_RANGE_EN
               if (NEG_EFF > 0) begin
                  w_state = NEG;
                  w_idx   = IDX_W'(1 - NEG_EFF);
               end else begin
                  w_state = POS;
                  w_idx   = IDX_ONE;
               end
`else
               w_state = POS;
               w_idx   = IDX_ONE;
`endif
               // A one-step sequence is first and last at once.
               w_last = (LAST_CNT == '0);
            end
         end

`ifdef CORDIC_EXT_RANGE_EN
         NEG: begin
            if (w_hs) begin
               w_cnt   = r_cnt + CNT_ONE;
               w_first = 1'b0;
               if (r_idx == '0) begin
                  w_state = POS;
                  w_idx   = IDX_ONE;
               end else begin
                  w_idx = r_idx + IDX_ONE;
               end
               w_last = (w_cnt == LAST_CNT);
            end
         end
`endif

         POS: begin
            if (w_hs) begin
               w_cnt = r_cnt + CNT_ONE;
               if (r_last) begin
                  w_state = DONE;
                  w_valid = 1'b0;
                  w_done  = 1'b1;
                  w_first = 1'b0;
                  w_last  = 1'b0;
                  w_rep   = 1'b0;
               end else begin
                  w_first = 1'b0;
                  if (r_idx == r_next_rep && !r_rep) begin
                     // Hyperbolic convergence needs this index issued twice.
                     w_rep = 1'b1;
                  end else if (r_rep) begin
                     // Repeat consumed: next repeat index is 3k+1.
                     w_next_rep = (r_next_rep <<< 1) + r_next_rep + IDX_ONE;
                     w_idx      = r_idx + IDX_ONE;
                     w_rep      = 1'b0;
                  end else begin
                     w_idx = r_idx + IDX_ONE;
                  end
                  // Step count reaching TOTAL-1 is exactly the issue with
                  // idx==LAST_IDX that has no repeat following it.
                  w_last = (w_cnt == LAST_CNT);
               end
            end
         end

         DONE: begin
            w_state = IDLE;
            w_busy  = 1'b0;
         end

         default: begin
            w_state = IDLE;
            w_valid = 1'b0;
            w_busy  = 1'b0;
         end
      endcase

      // Abort outranks any handshake or completion in the same cycle.
      if (abort && r_state != IDLE) begin
         w_state    = IDLE;
         w_idx      = '0;
         w_next_rep = REP_INIT;
         w_rep      = 1'b0;
         w_first    = 1'b0;
         w_last     = 1'b0;
         w_cnt      = '0;
         w_valid    = 1'b0;
         w_busy     = 1'b0;
         w_done     = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= IDLE;
         r_idx      <= '0;
         r_next_rep <= REP_INIT;
         r_rep      <= 1'b0;
         r_first    <= 1'b0;
         r_last     <= 1'b0;
         r_cnt      <= '0;
         r_valid    <= 1'b0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
      end else begin
         r_state    <= w_state;
         r_idx      <= w_idx;
         r_next_rep <= w_next_rep;
         r_rep      <= w_rep;
         r_first    <= w_first;
         r_last     <= w_last;
         r_cnt      <= w_cnt;
         r_valid    <= w_valid;
         r_busy     <= w_busy;
         r_done     <= w_done;
      end
   end

   assign busy       = r_busy;
   assign done       = r_done;
   assign step_valid = r_valid;
   assign step_idx   = r_idx;
   assign step_rep   = r_rep;
   assign step_first = r_first;
   assign step_last  = r_last;
   assign step_cnt   = r_cnt;

endmodule
